// File: rtl/johnson_pkg.sv
// Shared types, constants and helpers for the Johnson-counter phase monitor.
package johnson_pkg;

   localparam int unsigned JC_PHASES = 8;
   localparam int unsigned JC_CODE_W = 4;
   localparam int unsigned JC_IDX_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2,
      ST_FAULT  = 2'd3
   } jc_state_e;

   // Decoded view of one sampled code
   typedef struct packed {
      logic                legal;
      logic [JC_IDX_W-1:0] idx;
   } jc_dec_t;

   // Legal ring codes, entry i is the code for phase index i
   localparam logic [JC_PHASES-1:0][JC_CODE_W-1:0] JC_CODES = {
      4'b1000, 4'b1100, 4'b1110, 4'b1111,
      4'b0111, 4'b0011, 4'b0001, 4'b0000
   };

   // Next phase index around the ring (wraps 7 -> 0)
   function automatic logic [JC_IDX_W-1:0] jc_succ(input logic [JC_IDX_W-1:0] idx);
      return idx + JC_IDX_W'(1);
   endfunction

endpackage

// File: rtl/johnson_phase_monitor_if.sv
// Monitor-side bundle: ring code in, decoded phase and health flags out.
// rot_cnt exists only when JOHNSON_PHASE_MONITOR_ROT_COUNT_EN is defined.
interface johnson_phase_monitor_if #(
   parameter int unsigned ROT_W = 8
) ();
   import johnson_pkg::*;

   logic [JC_CODE_W-1:0] jc_in;
   logic                 jc_en;
   logic                 clr_fault;
   logic [JC_PHASES-1:0] phase;
   logic [JC_IDX_W-1:0]  phase_idx;
   logic                 locked;
   logic                 fault;
   logic                 err_illegal;
   logic                 err_seq;
`ifdef JOHNSON_PHASE_MONITOR_ROT_COUNT_EN
   logic [ROT_W-1:0]     rot_cnt;
`endif

   if (ROT_W < 1) begin : g_bad_rot_w
      $error("ROT_W must be at least 1");
   end

   modport master (
      output jc_in, jc_en, clr_fault,
      input  phase, phase_idx, locked, fault, err_illegal, err_seq
`ifdef JOHNSON_PHASE_MONITOR_ROT_COUNT_EN
      , input rot_cnt
`endif
   );

   modport slave (
      input  jc_in, jc_en, clr_fault,
      output phase, phase_idx, locked, fault, err_illegal, err_seq
`ifdef JOHNSON_PHASE_MONITOR_ROT_COUNT_EN
      , output rot_cnt
`endif
   );

endinterface

// File: rtl/johnson_code_decode.sv
// Combinational lookup of a 4-bit Johnson code into {legal, phase index}.
module johnson_code_decode
   import johnson_pkg::*;
(
   input  logic [JC_CODE_W-1:0] i_jc_in,
   output jc_dec_t              o_dec_c
);

   // Legal codes are unique, so at most one table entry can match
   always_comb begin
      o_dec_c = '0;
      for (int unsigned i = 0; i < JC_PHASES; i++) begin
         if (i_jc_in == JC_CODES[JC_IDX_W'(i)]) begin
            o_dec_c.legal = 1'b1;
            o_dec_c.idx   = JC_IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Johnson ring phase monitor: decodes the sampled code into a registered
// one-hot phase, checks legality and successor order, and runs the
// IDLE/TRACK/LOCKED/FAULT health FSM.
// Optional rotation counter: JOHNSON_PHASE_MONITOR_ROT_COUNT_EN.
module johnson_phase_monitor
   import johnson_pkg::*;
#(
   parameter int unsigned LOCK_CNT = 8,
   parameter int unsigned ROT_W    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   johnson_phase_monitor_if.slave bus
);

   localparam int unsigned      CNT_W     = 8;
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CNT - 1);
   localparam logic [JC_IDX_W-1:0] IDX_LAST = JC_IDX_W'(JC_PHASES - 1);

   if (LOCK_CNT < 2 || LOCK_CNT > 255) begin : g_bad_lock_cnt
      $error("LOCK_CNT must be in 2..255");
   end
   if (ROT_W < 1) begin : g_bad_rot_w
      $error("ROT_W must be at least 1");
   end

   jc_state_e            r_state;
   jc_state_e            w_state_nxt;
   logic [CNT_W-1:0]     r_good_cnt;
   logic [CNT_W-1:0]     w_good_cnt_nxt;
   logic                 r_hist_valid;

   jc_dec_t              w_dec;
   logic [JC_IDX_W-1:0]  w_exp_idx;
   logic                 w_illegal;
   logic                 w_good;
   logic                 w_bad_seq;

   logic [JC_PHASES-1:0] w_phase;
   logic [JC_IDX_W-1:0]  w_phase_idx;
   logic                 w_err_illegal;
   logic                 w_err_seq;

   logic [JC_PHASES-1:0] r_phase;
   logic [JC_IDX_W-1:0]  r_phase_idx;
   logic                 r_locked;
   logic                 r_fault;
   logic                 r_err_illegal;
   logic                 r_err_seq;

   johnson_code_decode u_decode (
      .i_jc_in (bus.jc_in),
      .o_dec_c (w_dec)
   );

   // r_phase_idx doubles as the history: it always holds the last legal index
   assign w_exp_idx = bus.jc_en ? jc_succ(r_phase_idx) : r_phase_idx;
   assign w_illegal = ~w_dec.legal;
   assign w_good    = w_dec.legal & r_hist_valid & (w_dec.idx == w_exp_idx);
   assign w_bad_seq = w_dec.legal & r_hist_valid & (w_dec.idx != w_exp_idx);

   // State and good-transition counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_good_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_good_cnt <= w_good_cnt_nxt;
      end
   end

   // Next-state: lock after LOCK_CNT consecutive good samples, FAULT is sticky until cleared
   always_comb begin
      w_state_nxt    = r_state;
      w_good_cnt_nxt = r_good_cnt;
      case (r_state)
         ST_IDLE: begin
            w_good_cnt_nxt = '0;
            if (w_dec.legal) w_state_nxt = ST_TRACK;
         end
         ST_TRACK: begin
            if (w_illegal) begin
               w_state_nxt    = ST_IDLE;
               w_good_cnt_nxt = '0;
            end else if (w_good) begin
               if (r_good_cnt == LOCK_LAST) begin
                  w_state_nxt    = ST_LOCKED;
                  w_good_cnt_nxt = '0;
               end else begin
                  w_good_cnt_nxt = r_good_cnt + CNT_W'(1);
               end
            end else begin
               w_good_cnt_nxt = '0;
            end
         end
         ST_LOCKED: begin
            if (!w_good) w_state_nxt = ST_FAULT;
         end
         ST_FAULT: begin
            if (bus.clr_fault) w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt    = ST_IDLE;
            w_good_cnt_nxt = '0;
         end
      endcase
   end

   // Output decode: phase strobe, index hold on illegal, error classification
   always_comb begin
      w_phase       = '0;
      w_phase_idx   = r_phase_idx;
      w_err_illegal = w_illegal;
      w_err_seq     = 1'b0;
      if (w_dec.legal) begin
         w_phase     = JC_PHASES'(1) << w_dec.idx;
         w_phase_idx = w_dec.idx;
      end
      if (r_state != ST_IDLE) w_err_seq = w_bad_seq;
   end

   // Registered outputs and history-valid flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase       <= '0;
         r_phase_idx   <= '0;
         r_hist_valid  <= 1'b0;
         r_locked      <= 1'b0;
         r_fault       <= 1'b0;
         r_err_illegal <= 1'b0;
         r_err_seq     <= 1'b0;
      end else begin
         r_phase       <= w_phase;
         r_phase_idx   <= w_phase_idx;
         r_hist_valid  <= r_hist_valid | w_dec.legal;
         r_locked      <= (w_state_nxt == ST_LOCKED);
         r_fault       <= (w_state_nxt == ST_FAULT);
         r_err_illegal <= w_err_illegal;
         r_err_seq     <= w_err_seq;
      end
   end

   assign bus.phase       = r_phase;
   assign bus.phase_idx   = r_phase_idx;
   assign bus.locked      = r_locked;
   assign bus.fault       = r_fault;
   assign bus.err_illegal = r_err_illegal;
   assign bus.err_seq     = r_err_seq;

`ifdef JOHNSON_PHASE_MONITOR_ROT_COUNT_EN
   logic             w_rot_inc;
   logic [ROT_W-1:0] r_rot_cnt;

   assign w_rot_inc = (r_state == ST_LOCKED) & w_good &
                      (r_phase_idx == IDX_LAST) & (w_dec.idx == '0);

   // Completed-rotation counter, advances on a good 7 -> 0 step while locked
   always_ff @(posedge clk) begin
      if (reset)          r_rot_cnt <= '0;
      else if (w_rot_inc) r_rot_cnt <= r_rot_cnt + ROT_W'(1);
   end

   assign bus.rot_cnt = r_rot_cnt;
`else
   logic w_unused_idx_last;
   assign w_unused_idx_last = &IDX_LAST;
`endif

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Self-checking bench for johnson_phase_monitor with a behavioural model.
module tb_johnson_phase_monitor;

   localparam int unsigned LOCK_CNT = 8;
   localparam int unsigned ROT_W    = 8;
   localparam int M_IDLE = 0, M_TRACK = 1, M_LOCKED = 2, M_FAULT = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   johnson_phase_monitor_if #(.ROT_W(ROT_W)) bus ();

   johnson_phase_monitor #(.LOCK_CNT(LOCK_CNT), .ROT_W(ROT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Model state
   int         m_mode   = M_IDLE;
   int         m_last   = -1;
   int         m_streak = 0;
   int         m_rot    = 0;
   logic [7:0] m_phase  = '0;
   int         m_idx    = 0;
   bit         m_eill   = 1'b0;
   bit         m_eseq   = 1'b0;
   int         s_k      = 0;

   // Johnson code of ring position k: k ones filled from the LSB, then drained from the LSB
   function automatic logic [3:0] ring_code(input int k);
      logic [3:0] c;
      if (k <= 4) c = 4'((1 << k) - 1);
      else        c = 4'(4'hF << (k - 4));
      return c;
   endfunction

   function automatic int code_index(input logic [3:0] c);
      for (int k = 0; k < 8; k++) if (ring_code(k) == c) return k;
      return -1;
   endfunction

   task automatic model_step(input bit rst, input logic [3:0] jc, input bit en, input bit clr);
      int k;
      int exp_k;
      bit good;
      if (rst) begin
         m_mode = M_IDLE; m_last = -1; m_streak = 0; m_rot = 0;
         m_phase = '0; m_idx = 0; m_eill = 0; m_eseq = 0;
         return;
      end
      k     = code_index(jc);
      exp_k = (m_last < 0) ? -1 : (en ? (m_last + 1) % 8 : m_last);
      good  = (k >= 0) && (k == exp_k);
      m_eill = (k < 0);
      m_eseq = (k >= 0) && (m_mode != M_IDLE) && !good;
      if (m_mode == M_LOCKED && good && m_last == 7 && k == 0)
         m_rot = (m_rot + 1) % (1 << ROT_W);
      case (m_mode)
         M_IDLE:   if (k >= 0) begin m_mode = M_TRACK; m_streak = 0; end
         M_TRACK: begin
            if (k < 0) m_mode = M_IDLE;
            else if (good) begin
               m_streak++;
               if (m_streak == int'(LOCK_CNT)) m_mode = M_LOCKED;
            end else m_streak = 0;
         end
         M_LOCKED: if (!good) m_mode = M_FAULT;
         default:  if (clr) m_mode = M_IDLE;
      endcase
      if (k >= 0) begin
         m_phase = 8'(1) << k; m_idx = k; m_last = k;
      end else begin
         m_phase = '0;
      end
   endtask

   function automatic logic [14:0] exp_vec();
      return {m_phase, 3'(m_idx), m_mode == M_LOCKED, m_mode == M_FAULT, m_eill, m_eseq};
   endfunction

   function automatic logic [14:0] obs_vec();
      return {bus.phase, bus.phase_idx, bus.locked, bus.fault, bus.err_illegal, bus.err_seq};
   endfunction

   task automatic cycle(input bit rst, input logic [3:0] jc, input bit en, input bit clr);
      reset = rst; bus.jc_in = jc; bus.jc_en = en; bus.clr_fault = clr;
      @(posedge clk);
      model_step(rst, jc, en, clr);
      if (!rst && code_index(jc) >= 0) s_k = code_index(jc);
      #1;
   endtask

   task automatic test_reset();
      cycle(1, 4'b0000, 0, 0);
      cycle(1, 4'b0101, 1, 1);
      checks++;
      if (obs_vec() !== 15'h0) begin
         errors++; $display("FAIL reset_outputs: got %h want %h", obs_vec(), 15'h0);
      end
`ifdef JOHNSON_PHASE_MONITOR_ROT_COUNT_EN
      checks++;
      if (bus.rot_cnt !== '0) begin
         errors++; $display("FAIL reset_rot: got %0d want 0", bus.rot_cnt);
      end
`endif
   endtask

   task automatic test_lock_sequence();
      for (int i = 0; i < 24; i++) begin
         cycle(0, ring_code(i % 8), 1, 0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL lock_seq_model cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
         end
         checks++;
         if (bus.phase !== (8'(1) << (i % 8)) || bus.locked !== (i >= int'(LOCK_CNT))) begin
            errors++; $display("FAIL lock_seq_direct cyc %0d: phase %h locked %b", i, bus.phase, bus.locked);
         end
`ifdef JOHNSON_PHASE_MONITOR_ROT_COUNT_EN
         checks++;
         if (bus.rot_cnt !== ROT_W'((i >= 16) ? 1 : 0)) begin
            errors++; $display("FAIL lock_seq_rot cyc %0d: got %0d want %0d", i, bus.rot_cnt, (i >= 16) ? 1 : 0);
         end
`endif
      end
   endtask

   task automatic test_illegal_in_locked();
      cycle(0, 4'b0101, 1, 0);
      checks++;
      if ({bus.err_illegal, bus.err_seq, bus.phase, bus.phase_idx, bus.fault, bus.locked} !== {2'b10, 8'h00, 3'd7, 2'b10}) begin
         errors++; $display("FAIL illegal_locked: got %h want %h", obs_vec(), exp_vec());
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL illegal_locked_model: got %h want %h", obs_vec(), exp_vec());
      end
      cycle(0, ring_code(0), 1, 0);
      checks++;
      if (bus.err_illegal !== 1'b0 || bus.fault !== 1'b1 || bus.phase !== 8'h01) begin
         errors++; $display("FAIL illegal_pulse_end: got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_skip_in_locked();
      cycle(0, ring_code(1), 1, 1);
      checks++;
      if (bus.fault !== 1'b0 || obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL skip_clear: got %h want %h", obs_vec(), exp_vec());
      end
      for (int i = 0; i < 9; i++) begin
         cycle(0, ring_code((2 + i) % 8), 1, 0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL skip_relock cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (bus.locked !== 1'b1 || bus.phase !== 8'h04) begin
         errors++; $display("FAIL skip_prelocked: got locked %b phase %h want 1 04", bus.locked, bus.phase);
      end
      cycle(0, 4'b1111, 1, 0);
      checks++;
      if ({bus.err_seq, bus.err_illegal, bus.fault, bus.locked, bus.phase, bus.phase_idx} !== {4'b1010, 8'h10, 3'd4}) begin
         errors++; $display("FAIL skip_locked: got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_hold_lock_then_advance();
      cycle(0, 4'b0111, 0, 1);
      cycle(0, 4'b0111, 0, 0);
      checks++;
      if (bus.fault !== 1'b0 || obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL hold_enter: got %h want %h", obs_vec(), exp_vec());
      end
      for (int i = 0; i < 10; i++) begin
         cycle(0, 4'b0111, 0, 0);
         checks++;
         if (obs_vec() !== exp_vec() || bus.locked !== (i >= int'(LOCK_CNT) - 1)) begin
            errors++; $display("FAIL hold cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      cycle(0, 4'b1111, 0, 0);
      checks++;
      if (bus.err_seq !== 1'b1 || bus.fault !== 1'b1 || bus.locked !== 1'b0 || obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL hold_advance: got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_clear_with_illegal();
      cycle(0, 4'b1010, 1, 1);
      checks++;
      if ({bus.fault, bus.err_illegal, bus.err_seq, bus.locked, bus.phase, bus.phase_idx} !== {4'b0100, 8'h00, 3'd4}) begin
         errors++; $display("FAIL clear_illegal: got %h want %h", obs_vec(), exp_vec());
      end
      // out-of-order legal code: no err_seq because the monitor is back in IDLE
      cycle(0, ring_code(1), 1, 0);
      checks++;
      if (bus.err_seq !== 1'b0 || bus.fault !== 1'b0 || obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL clear_then_idle: got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_reset_mid_locked();
      for (int n = 1; n <= 12; n++) begin
         cycle(0, ring_code((1 + n) % 8), 1, (n % 3) == 0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL rst_mid_run cyc %0d: got %h want %h", n, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (bus.locked !== 1'b1 || bus.phase_idx !== 3'd5) begin
         errors++; $display("FAIL rst_mid_prelock: locked %b idx %0d want 1 5", bus.locked, bus.phase_idx);
      end
      cycle(1, ring_code(6), 1, 0);
      checks++;
      if (obs_vec() !== 15'h0) begin
         errors++; $display("FAIL rst_mid_outputs: got %h want %h", obs_vec(), 15'h0);
      end
`ifdef JOHNSON_PHASE_MONITOR_ROT_COUNT_EN
      checks++;
      if (bus.rot_cnt !== '0) begin
         errors++; $display("FAIL rst_mid_rot: got %0d want 0", bus.rot_cnt);
      end
`endif
      cycle(0, ring_code(3), 1, 0);
      checks++;
      if (bus.err_seq !== 1'b0 || bus.err_illegal !== 1'b0 || bus.phase !== 8'h08 || bus.locked !== 1'b0) begin
         errors++; $display("FAIL rst_first_sample: got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      logic [3:0] c;
      int r;
      bit en, clr, rst;
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 99));
         rst = (r < 2); en = 1'b1; clr = 1'b0;
         if (r < 70) begin
            c = ring_code((s_k + 1) % 8);
         end else if (r < 80) begin
            en = 1'b0; c = ring_code(s_k);
         end else if (r < 87) begin
            do c = 4'($urandom_range(0, 15)); while (code_index(c) >= 0);
         end else if (r < 94) begin
            en = 1'($urandom_range(0, 1)); c = ring_code(int'($urandom_range(0, 7)));
         end else begin
            clr = 1'b1; c = ring_code((s_k + 1) % 8);
         end
         cycle(rst, c, en, clr);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
         end
`ifdef JOHNSON_PHASE_MONITOR_ROT_COUNT_EN
         checks++;
         if (bus.rot_cnt !== ROT_W'(m_rot)) begin
            errors++; $display("FAIL random_rot cyc %0d: got %0d want %0d", i, bus.rot_cnt, m_rot);
         end
`endif
      end
   endtask

   initial begin
      reset = 1'b1; bus.jc_in = '0; bus.jc_en = 1'b0; bus.clr_fault = 1'b0;
      test_reset();
      test_lock_sequence();
      test_illegal_in_locked();
      test_skip_in_locked();
      test_hold_lock_then_advance();
      test_clear_with_illegal();
      test_reset_mid_locked();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/johnson_phase_monitor.md
# johnson_phase_monitor

Downstream consumer of the 4-bit Johnson counter. It samples the counter's 4-bit code every clock and decodes it into a registered one-hot 8-phase strobe plus a phase index. It also checks code legality and successor ordering, and runs a lock/fault state machine. Phase-sequenced logic uses its outputs as qualified timing strobes, and control logic uses them as a health indication for the ring.

## Interface
- `LOCK_CNT`, default 8: consecutive correct transitions required to declare lock (range 2..255).
- `ROT_W`, default 8: width of the rotation counter.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high; overrides every other input.
- `jc_in`  in  4: Johnson code from the counter's `out`.
- `jc_en`  in  1: 1 means the code must advance to its successor each cycle; 0 means the code must hold.
- `clr_fault`  in  1: single-cycle request to leave FAULT.
- `phase`  out  8: one-hot decoded phase, registered.
- `phase_idx`  out  3: index 0..7 of the last legal code.
- `locked`  out  1: high while in LOCKED.
- `fault`  out  1: high while in FAULT.
- `err_illegal`  out  1: one-cycle pulse when an illegal code is sampled.
- `err_seq`  out  1: one-cycle pulse when a legal code breaks sequence.
- `rot_cnt`  out  `ROT_W`: completed rotations (only with the macro).

## Operation
- Legal sequence, indices 0..7: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then wraps to 0000. The other 8 codes are illegal.
- Expected code:
  - `jc_en=1`: successor of the previously sampled legal index, mod 8.
  - `jc_en=0`: the same index.
- A "good" sample is legal and equal to the expected code. A "bad" sample is illegal or out of sequence.
- FSM states: IDLE, TRACK, LOCKED, FAULT.
  - IDLE: no comparison is made. A legal sample goes to TRACK with `good_cnt=0`. An illegal sample stays in IDLE and pulses `err_illegal`.
  - TRACK:
    - good: `good_cnt++`; when `good_cnt` reaches `LOCK_CNT-1`, go to LOCKED.
    - bad legal: pulse `err_seq`, clear `good_cnt`, restart tracking from the new code, stay in TRACK.
    - illegal: pulse `err_illegal`, go to IDLE.
  - LOCKED: good stays in LOCKED. Any bad sample pulses the matching error and goes to FAULT.
  - FAULT: sticky. `clr_fault=1` goes to IDLE. Error pulses are still produced in FAULT.
- `phase`:
  - legal sample: `phase = 1<<idx` and `phase_idx = idx`.
  - illegal sample: `phase = 0`; `phase_idx` holds its previous value.
- `clr_fault` outside FAULT is ignored.
- If `clr_fault` coincides with a bad sample in FAULT, the clear wins (next state IDLE) and the error pulse is still emitted.

## Timing
- Latency: every output reflects the `jc_in`/`jc_en` sampled at the previous rising edge (1 cycle).
- Reset values: `phase=0`, `phase_idx=0`, `locked=0`, `fault=0`, `err_illegal=0`, `err_seq=0`, `rot_cnt=0`; state IDLE; `good_cnt=0`; history invalid.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. The first post-reset sample is never compared.
- Lock timing: with a clean advancing ring, the first legal sample enters TRACK. `locked` rises `LOCK_CNT` cycles after the edge at which TRACK was entered.
- `err_illegal` and `err_seq` are mutually exclusive and never asserted in the same cycle.
- `rot_cnt` increments, with wrap modulo 2^`ROT_W`, on a good 7→0 transition while LOCKED.

## Configuration
- Macro: `JOHNSON_PHASE_MONITOR_ROT_COUNT_EN`.
- Defined: the `rot_cnt` port and its counter exist.
- Undefined: the port and counter are removed; all other behaviour is identical.

## Structure
- Shared package `johnson_pkg`:
  - FSM state typedef (IDLE/TRACK/LOCKED/FAULT).
  - Legal code table (8 × 4-bit).
  - `JC_PHASES=8`.
  - Successor function on a 3-bit index.
- One sub-module, `johnson_code_decode` (combinational): maps `jc_in` to {legal, idx[2:0]}. The top-level holds the registers and the FSM.

## Test plan
- Reset, then drive the clean sequence from 0000 with `jc_en=1` and `LOCK_CNT=8`:
  - `phase` walks 0x01, 0x02, … 0x80, 0x01 with 1-cycle lag.
  - `locked` rises 8 cycles after TRACK entry.
  - `rot_cnt` increments on each 1000→0000 while locked.
- While LOCKED, inject 0101: `err_illegal` pulses 1 cycle, `phase=0`, `phase_idx` holds, `fault=1`, `locked=0`.
- While LOCKED, skip from 0011 to 1111: `err_seq` pulses, `fault=1`, `phase=0x10`.
- In TRACK, hold 0111 with `jc_en=0` for 10 cycles: `locked` rises; then advance without asserting `jc_en`: `err_seq` pulses and the state goes to FAULT.
- In FAULT, pulse `clr_fault` together with an illegal code: next state IDLE, `fault=0`, `err_illegal` pulses.
- Assert `reset` mid-LOCKED at index 5: next cycle all outputs are 0, state IDLE, and `rot_cnt=0`.
